fetch_sequencer: RTL and testbench

//  Instruction-fetch controller. Drives PC_Register updates and the instruction-memory req/ack handshake.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_sequencer_if.sv | 24 ++
 rtl/fetch_wait_timer.sv | 36 +++
 rtl/fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding and
// default fetch parameters.
package fetch_pkg;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    localparam int unsigned  DefPcStep      = 4;
    localparam logic [31:0]  DefResetVector = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer
// (master) and instruction memory (slave).
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_wait_timer.sv
// Saturating count of consecutive unacknowledged request cycles, with a sticky
// timeout flag once the count reaches MAX_WAIT.
module fetch_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic Clk,
    input  logic R,
    input  logic req,
    input  logic ack,
    output logic timeout
);
    localparam int unsigned     CntW   = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Count waiting cycles; any ack or idle cycle restarts the count.
    always_comb begin
        cnt_d = '0;
        if (req && !ack) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Counter and sticky timeout, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (!R) begin
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            timeout <= timeout | (cnt_d == CntMax);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the imem req/ack handshake, keeps a
// one-entry buffer toward decode, honours stalls and redirects on taken
// branches (flush, drain the in-flight request, restart at the target).
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DefResetVector),
    parameter int unsigned       PC_STEP      = DefPcStep,
    parameter int unsigned       MAX_WAIT     = 15
) (
    input  logic              Clk,
    input  logic              R,
    fetch_sequencer_if.master imem,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              flush,
    output logic              timeout,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
);
    localparam logic [ADDR_W-1:0] PcInc = ADDR_W'(PC_STEP);

    fetch_state_e      state;
    logic [ADDR_W-1:0] drain_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic              req;
    logic              ack;
    logic              buf_free;

    assign ack = imem.imem_ack;

    // Request generation. While a request waits for its ack the buffer has
    // already been consumed, so buf_free stays high and req cannot drop.
    always_comb begin
        buf_free   = !instr_valid || !stall;
        req        = 1'b0;
        fetch_addr = pc;
        unique case (state)
            StBoot:  req = 1'b0;
            StFetch: req = buf_free;
            StDrain: begin
                req        = 1'b1;
                fetch_addr = drain_addr;
            end
            default: req = 1'b0;
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_addr;

    // Fetch FSM with registered buffer, pc and flush; branches win over ack/stall.
    always_ff @(posedge Clk) begin
        if (!R) begin
            state       <= StBoot;
            pc          <= RESET_VECTOR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            flush       <= 1'b0;
            drain_addr  <= '0;
        end else begin
            flush <= 1'b0;
            unique case (state)
                StBoot: state <= StFetch;
                StFetch: begin
                    if (br_taken) begin
                        pc          <= br_target;
                        instr_valid <= 1'b0;
                        flush       <= 1'b1;
                        // An unacked request must complete before the target is fetched.
                        if (req && !ack) begin
                            drain_addr <= fetch_addr;
                            state      <= StDrain;
                        end
                    end else if (req && ack) begin
                        instr       <= imem.imem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + PcInc;
                    end else if (instr_valid && !stall) begin
                        instr_valid <= 1'b0;
                    end
                end
                StDrain: begin
                    if (br_taken) begin
                        pc    <= br_target;
                        flush <= 1'b1;
                    end
                    // Drained data is discarded; resume fetching at pc.
                    if (ack) begin
                        state <= StFetch;
                    end
                end
                default: state <= StBoot;
            endcase
        end
    end

    fetch_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .Clk     (Clk),
        .R       (R),
        .req     (req),
        .ack     (ack),
        .timeout (timeout)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Accepted fetches (drained or branch-squashed acks excluded) and stalled cycles.
    always_ff @(posedge Clk) begin
        if (!R) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state == StFetch && req && ack && !br_taken) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (instr_valid && stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural instruction memory
// with programmable latency and ack budget, plus a decode-side scoreboard.
module tb_fetch_sequencer;
    localparam int unsigned ADDR_W = 32;
`ifdef FETCH_PERF_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic              Clk = 1'b0;
    logic              R = 1'b0;
    logic              stall = 1'b0;
    logic              br_taken = 1'b0;
    logic [ADDR_W-1:0] br_target = '0;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              flush;
    logic              timeout;
    logic [31:0]       fetch_cnt;
    logic [31:0]       stall_cnt;

    fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_sequencer #(
        .ADDR_W       (ADDR_W),
        .RESET_VECTOR (32'h0),
        .PC_STEP      (4),
        .MAX_WAIT     (15)
    ) dut (
        .Clk         (Clk),
        .R           (R),
        .imem        (bus.master),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pc          (pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .flush       (flush),
        .timeout     (timeout),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 Clk = ~Clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   mem_lat = 0;
    int   mem_limit = 0;
    int   mem_acks = 0;
    int   mem_wait = 0;

    // One clock cycle: memory responds and decode consumes at the falling
    // edge, then return just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge Clk);
        if (!R) begin
            bus.imem_ack  = 1'b0;
            bus.imem_data = '0;
            mem_acks      = 0;
            mem_wait      = 0;
        end else if (bus.imem_req && mem_acks < mem_limit && mem_wait >= mem_lat) begin
            bus.imem_ack  = 1'b1;
            bus.imem_data = ~bus.imem_addr;
            mem_acks++;
            mem_wait = 0;
        end else begin
            bus.imem_ack = 1'b0;
            mem_wait     = bus.imem_req ? mem_wait + 1 : 0;
        end
        if (R && instr_valid && !stall && !br_taken) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: got instr_pc=%h, required no instruction", instr_pc);
            end else begin
                e = sb.pop_front();
                if (instr !== e.data || instr_pc !== e.pc) begin
                    n_bad++;
                    $display("FAIL sb_instr: got pc=%h data=%h, required pc=%h data=%h",
                             instr_pc, instr, e.pc, e.data);
                end
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.data = ~a;
        sb.push_back(e);
    endtask

    // Two reset edges, then release: returns at the start of cycle 1 (BOOT).
    task automatic do_reset();
        R         = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        mem_limit = 0;
        mem_lat   = 0;
        sb.delete();
        tick();
        tick();
        R = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        R = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %b want 0", flush); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        n_cmp++; if (fetch_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_fcnt: got %0d want 0", fetch_cnt); end
        n_cmp++; if (stall_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_scnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_fetch();
        do_reset();
        mem_limit = 4;
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL f_boot_req: got %b want 0", bus.imem_req); end
        tick();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL f_first_req: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL f_valid_c2: got %b want 0", instr_valid); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            n_bad++; $display("FAIL f_valid_c3: got v=%b pc=%h want 1/0", instr_valid, instr_pc); end
        repeat (4) tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL f_consumed: got %b want 0", instr_valid); end
        n_cmp++; if (pc !== 32'h10 || bus.imem_addr !== 32'h10 || bus.imem_req !== 1'b1) begin
            n_bad++; $display("FAIL f_next: got pc=%h addr=%h req=%b want 10/10/1", pc, bus.imem_addr, bus.imem_req); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL f_sb_left: got %0d want 0", sb.size()); end
        n_cmp++; if (fetch_cnt !== (Perf ? 32'd4 : 32'd0)) begin
            n_bad++; $display("FAIL f_fcnt: got %0d want %0d", fetch_cnt, Perf ? 4 : 0); end
    endtask

    task automatic test_stall();
        do_reset();
        mem_limit = 3;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        tick();
        tick();
        tick();
        stall = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL s_req_%0d: got %b want 0", c, bus.imem_req); end
            n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== ~32'h4) begin
                n_bad++; $display("FAIL s_hold_%0d: got v=%b pc=%h d=%h want 1/4/%h", c, instr_valid, instr_pc, instr, ~32'h4); end
            tick();
        end
        stall = 1'b0;
        #1;
        n_cmp++; if (stall_cnt !== (Perf ? 32'd3 : 32'd0)) begin
            n_bad++; $display("FAIL s_scnt: got %0d want %0d", stall_cnt, Perf ? 3 : 0); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
            n_bad++; $display("FAIL s_resume: got req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr); end
        tick();
        tick();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL s_sb_left: got %0d want 0", sb.size()); end
        n_cmp++; if (fetch_cnt !== (Perf ? 32'd3 : 32'd0)) begin
            n_bad++; $display("FAIL s_fcnt: got %0d want %0d", fetch_cnt, Perf ? 3 : 0); end
    endtask

    task automatic test_branch_drain();
        do_reset();
        mem_lat   = 3;
        mem_limit = 2;
        push_exp(32'h100);
        tick();
        tick();
        br_taken  = 1'b1;
        br_target = 32'h100;
        tick();
        br_taken = 1'b0;
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL d_flush: got %b want 1", flush); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || pc !== 32'h100) begin
            n_bad++; $display("FAIL d_drain: got req=%b addr=%h pc=%h want 1/0/100", bus.imem_req, bus.imem_addr, pc); end
        tick();
        n_cmp++; if (flush !== 1'b0 || bus.imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL d_hold: got flush=%b addr=%h want 0/0", flush, bus.imem_addr); end
        tick();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL d_restart: got req=%b addr=%h v=%b want 1/100/0", bus.imem_req, bus.imem_addr, instr_valid); end
        repeat (4) tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            n_bad++; $display("FAIL d_target: got v=%b pc=%h want 1/100", instr_valid, instr_pc); end
        tick();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL d_sb_left: got %0d want 0", sb.size()); end
        n_cmp++; if (fetch_cnt !== (Perf ? 32'd1 : 32'd0)) begin
            n_bad++; $display("FAIL d_fcnt: got %0d want %0d", fetch_cnt, Perf ? 1 : 0); end
    endtask

    task automatic test_branch_ack();
        do_reset();
        mem_limit = 4;
        push_exp(32'h0); push_exp(32'h100);
        tick();
        tick();
        tick();
        br_taken  = 1'b1;
        br_target = 32'h100;
        tick();
        br_taken = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || flush !== 1'b1) begin
            n_bad++; $display("FAIL a_squash: got v=%b flush=%b want 0/1", instr_valid, flush); end
        n_cmp++; if (pc !== 32'h100 || bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1) begin
            n_bad++; $display("FAIL a_target: got pc=%h addr=%h req=%b want 100/100/1", pc, bus.imem_addr, bus.imem_req); end
        n_cmp++; if (fetch_cnt !== (Perf ? 32'd2 : 32'd0)) begin
            n_bad++; $display("FAIL a_fcnt: got %0d want %0d", fetch_cnt, Perf ? 2 : 0); end
        tick();
        n_cmp++; if (flush !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            n_bad++; $display("FAIL a_refill: got flush=%b v=%b pc=%h want 0/1/100", flush, instr_valid, instr_pc); end
        tick();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL a_sb_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL t_req: got %b want 1", bus.imem_req); end
        repeat (14) tick();
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL t_early: got %b want 0", timeout); end
        tick();
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL t_fire: got %b want 1", timeout); end
        repeat (8) tick();
        n_cmp++; if (timeout !== 1'b1 || bus.imem_req !== 1'b1) begin
            n_bad++; $display("FAIL t_sticky: got to=%b req=%b want 1/1", timeout, bus.imem_req); end
        R = 1'b0;
        tick();
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL t_clear: got %b want 0", timeout); end
    endtask

    task automatic test_reset_drain();
        do_reset();
        mem_lat   = 3;
        mem_limit = 2;
        tick();
        br_taken  = 1'b1;
        br_target = 32'h100;
        tick();
        br_taken = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || pc !== 32'h100) begin
            n_bad++; $display("FAIL r_in_drain: got req=%b pc=%h want 1/100", bus.imem_req, pc); end
        R = 1'b0;
        tick();
        n_cmp++; if (bus.imem_req !== 1'b0 || pc !== 32'h0 || flush !== 1'b0) begin
            n_bad++; $display("FAIL r_state: got req=%b pc=%h flush=%b want 0/0/0", bus.imem_req, pc, flush); end
        n_cmp++; if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instr !== 32'h0 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL r_buf: got v=%b pc=%h d=%h to=%b want 0/0/0/0", instr_valid, instr_pc, instr, timeout); end
        n_cmp++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
            n_bad++; $display("FAIL r_cnt: got f=%0d s=%0d want 0/0", fetch_cnt, stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch_drain();
        test_branch_ack();
        test_timeout();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
